ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage that sits directly upstream of the 32-bit ALU.
- Captures decoded instruction fields from decode each cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and inserts one bubble on a load-use hazard.
- Drives the ALU operands A and B and the 4-bit ALUop, plus the control fields that travel down the pipeline.

Parameters:
XLEN, 32, datapath width
ALUOP_W, 4, ALUop width (same encoding as ALUop.vh)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  decode presents a valid instruction
in_ready  out  1  stage can accept this cycle (0 = stall decode)
in_pc  in  XLEN  instruction PC
in_rs1_data  in  XLEN  regfile read data rs1
in_rs2_data  in  XLEN  regfile read data rs2
in_rs1_addr  in  5  rs1 index
in_rs2_addr  in  5  rs2 index
in_use_rs1  in  1  instruction reads rs1
in_use_rs2  in  1  instruction reads rs2
in_imm  in  XLEN  sign-extended immediate
in_a_sel  in  1  0 = rs1, 1 = PC
in_b_sel  in  1  0 = rs2, 1 = imm
in_alu_op  in  ALUOP_W  ALU operation
in_rd_addr  in  5  destination index
in_reg_write  in  1  writes rd
in_mem_read  in  1  is a load
flush  in  1  kill instruction held in stage (branch/jump redirect)
exmem_rd_addr  in  5  EX/MEM destination
exmem_reg_write  in  1  EX/MEM writes rd
exmem_mem_read  in  1  EX/MEM is a load (result not yet available)
exmem_result  in  XLEN  EX/MEM ALU result
memwb_rd_addr  in  5  MEM/WB destination
memwb_reg_write  in  1  MEM/WB writes rd
memwb_result  in  XLEN  MEM/WB writeback value
alu_a  out  XLEN  ALU operand A
alu_b  out  XLEN  ALU operand B
alu_op  out  ALUOP_W  ALUop to ALU
out_valid  out  1  alu_* carry a real instruction this cycle
out_store_data  out  XLEN  forwarded rs2, independent of b_sel
out_pc  out  XLEN  registered PC
out_rd_addr  out  5  registered rd
out_reg_write  out  1  registered reg_write AND out_valid
out_mem_read  out  1  registered mem_read AND out_valid

Behaviour:
- Register: valid bit plus all in_* fields. Capture when in_ready=1 (in_valid is stored as the valid bit, so an invalid input becomes a bubble). When in_ready=0, hold all fields.
- Latency: 1 cycle, from capture edge to alu_a/alu_b/alu_op.
- Forwarding (combinational on registered fields), evaluated separately for rs1 and rs2:
  - EX/MEM hit if exmem_reg_write & exmem_rd_addr!=0 & exmem_rd_addr==rs.
  - Else MEM/WB hit if memwb_reg_write & memwb_rd_addr!=0 & memwb_rd_addr==rs.
  - Else use the registered regfile data.
  - EX/MEM has priority. Index 0 is never forwarded.
- Operand select:
  - alu_a = a_sel ? pc : fwd_rs1.
  - alu_b = b_sel ? imm : fwd_rs2.
  - out_store_data = fwd_rs2.
- Load-use hazard: hazard = valid & exmem_mem_read & exmem_reg_write & exmem_rd_addr!=0 & ((use_rs1 & rs1==exmem_rd_addr) | (use_rs2 & rs2==exmem_rd_addr)).
- While hazard=1:
  - out_valid=0, out_reg_write=0, out_mem_read=0 (bubble to EX/MEM).
  - in_ready=0; stage holds.
  - Next cycle the load is in MEM/WB and is forwarded from memwb_result. At most 1 consecutive stall cycle per load.
- Otherwise out_valid=valid and in_ready=1.
- Flush (priority over hazard and capture):
  - Next edge: valid <= 0 and the incoming instruction is discarded.
  - in_ready=1 during flush, so decode is not held.
  - Output gating during the flush cycle itself is unchanged; the kill takes effect at the edge.
- Reset:
  - All registered fields <= 0, valid <= 0.
  - Outputs after reset: out_valid=0, out_reg_write=0, out_mem_read=0, alu_a=0, alu_b=0, alu_op=0, out_pc=0, out_rd_addr=0, out_store_data=0, in_ready=1.
  - Reset mid-stall clears the stall.
- Simultaneous events: flush+hazard resolves to flush. If EX/MEM and MEM/WB both match, EX/MEM wins. A non-load EX/MEM match never stalls.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, alu_a=alu_b=0, in_ready=1.
- Plain capture: ADD x3,x1,x2 with rs1_data=5, rs2_data=7, no matches -> next cycle alu_a=5, alu_b=7, alu_op=ALU_ADD, out_valid=1, out_reg_write=1.
- Forward priority: rs1=x4; exmem rd=x4 result=0x11; memwb rd=x4 result=0x22 -> alu_a=0x11. With exmem_reg_write=0 -> alu_a=0x22. With rs1=x0 and both matching x0 -> alu_a=registered data.
- Load-use: EX/MEM load rd=x5 (exmem_mem_read=1), stage holds ADD using x5 -> 1 cycle out_valid=0, in_ready=0, decode held. Next cycle memwb rd=x5 result=0x99 -> alu_a=0x99, out_valid=1. I-type with use_rs2=0 and rs2 field=x5 -> no stall.
- Immediate/PC select: a_sel=1, b_sel=1, pc=0x1000, imm=0xFFFFFFFC -> alu_a=0x1000, alu_b=0xFFFFFFFC. out_store_data still equals forwarded rs2.
- Flush during stall: hazard active and flush=1 -> next cycle valid=0, in_ready=1, new instruction captured the following cycle.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register and ALU operand select.
// Holds one decoded instruction, forwards EX/MEM and MEM/WB results into
// rs1/rs2, inserts a single bubble on a load-use hazard and drives the
// ALU operands plus the control fields that continue down the pipeline.
module ex_operand_stage #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [4:0]         in_rs1_addr,
    input  logic [4:0]         in_rs2_addr,
    input  logic               in_use_rs1,
    input  logic               in_use_rs2,
    input  logic [XLEN-1:0]    in_imm,
    input  logic               in_a_sel,
    input  logic               in_b_sel,
    input  logic [ALUOP_W-1:0] in_alu_op,
    input  logic [4:0]         in_rd_addr,
    input  logic               in_reg_write,
    input  logic               in_mem_read,
    input  logic               flush,
    input  logic [4:0]         exmem_rd_addr,
    input  logic               exmem_reg_write,
    input  logic               exmem_mem_read,
    input  logic [XLEN-1:0]    exmem_result,
    input  logic [4:0]         memwb_rd_addr,
    input  logic               memwb_reg_write,
    input  logic [XLEN-1:0]    memwb_result,
    output logic [XLEN-1:0]    alu_a,
    output logic [XLEN-1:0]    alu_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               out_valid,
    output logic [XLEN-1:0]    out_store_data,
    output logic [XLEN-1:0]    out_pc,
    output logic [4:0]         out_rd_addr,
    output logic               out_reg_write,
    output logic               out_mem_read
);

    // Registered instruction fields
    logic               valid_q;
    logic               valid_d;
    logic [XLEN-1:0]    pc_q;
    logic [XLEN-1:0]    rs1_data_q;
    logic [XLEN-1:0]    rs2_data_q;
    logic [4:0]         rs1_addr_q;
    logic [4:0]         rs2_addr_q;
    logic               use_rs1_q;
    logic               use_rs2_q;
    logic [XLEN-1:0]    imm_q;
    logic               a_sel_q;
    logic               b_sel_q;
    logic [ALUOP_W-1:0] alu_op_q;
    logic [4:0]         rd_addr_q;
    logic               reg_write_q;
    logic               mem_read_q;

    logic               capture_en;
    logic               hazard;
    logic               exmem_fwd_ok;
    logic               memwb_fwd_ok;
    logic [XLEN-1:0]    fwd_rs1;
    logic [XLEN-1:0]    fwd_rs2;

    // A producer only forwards when it writes a non-zero register.
    assign exmem_fwd_ok = exmem_reg_write && (exmem_rd_addr != 5'd0);
    assign memwb_fwd_ok = memwb_reg_write && (memwb_rd_addr != 5'd0);

    // Load-use detection: a load in EX/MEM cannot supply its data yet, so a
    // consumer of its rd must wait one cycle and pick it up from MEM/WB.
    assign hazard = valid_q && exmem_mem_read && exmem_fwd_ok &&
                    ((use_rs1_q && (rs1_addr_q == exmem_rd_addr)) ||
                     (use_rs2_q && (rs2_addr_q == exmem_rd_addr)));

    // Flush frees decode even while a hazard would otherwise hold it.
    assign in_ready   = flush || !hazard;
    assign capture_en = !flush && !hazard;

    // Operand forwarding with EX/MEM taking priority over MEM/WB.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        fwd_rs2 = rs2_data_q;
        if (exmem_fwd_ok && (exmem_rd_addr == rs1_addr_q)) begin
            fwd_rs1 = exmem_result;
        end else if (memwb_fwd_ok && (memwb_rd_addr == rs1_addr_q)) begin
            fwd_rs1 = memwb_result;
        end
        if (exmem_fwd_ok && (exmem_rd_addr == rs2_addr_q)) begin
            fwd_rs2 = exmem_result;
        end else if (memwb_fwd_ok && (memwb_rd_addr == rs2_addr_q)) begin
            fwd_rs2 = memwb_result;
        end
    end

    // Next valid bit: flush kills, capture takes decode's valid, else hold.
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture_en) begin
            valid_d = in_valid;
        end
    end

    // Pipeline register; fields are held while stalled or flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            use_rs1_q   <= 1'b0;
            use_rs2_q   <= 1'b0;
            imm_q       <= '0;
            a_sel_q     <= 1'b0;
            b_sel_q     <= 1'b0;
            alu_op_q    <= '0;
            rd_addr_q   <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (capture_en) begin
                pc_q        <= in_pc;
                rs1_data_q  <= in_rs1_data;
                rs2_data_q  <= in_rs2_data;
                rs1_addr_q  <= in_rs1_addr;
                rs2_addr_q  <= in_rs2_addr;
                use_rs1_q   <= in_use_rs1;
                use_rs2_q   <= in_use_rs2;
                imm_q       <= in_imm;
                a_sel_q     <= in_a_sel;
                b_sel_q     <= in_b_sel;
                alu_op_q    <= in_alu_op;
                rd_addr_q   <= in_rd_addr;
                reg_write_q <= in_reg_write;
                mem_read_q  <= in_mem_read;
            end
        end
    end

    assign alu_a          = a_sel_q ? pc_q  : fwd_rs1;
    assign alu_b          = b_sel_q ? imm_q : fwd_rs2;
    assign alu_op         = alu_op_q;
    assign out_store_data = fwd_rs2;
    assign out_pc         = pc_q;
    assign out_rd_addr    = rd_addr_q;
    assign out_valid      = valid_q && !hazard;
    assign out_reg_write  = reg_write_q && out_valid;
    assign out_mem_read   = mem_read_q && out_valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed testbench for ex_operand_stage with an instruction-level model
// compared against the DUT on every falling edge.
module tb_ex_operand_stage;

    localparam int XLEN    = 32;
    localparam int ALUOP_W = 4;
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h8;
    localparam logic [3:0] ALU_OR  = 4'h6;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    in_pc;
    logic [XLEN-1:0]    in_rs1_data;
    logic [XLEN-1:0]    in_rs2_data;
    logic [4:0]         in_rs1_addr;
    logic [4:0]         in_rs2_addr;
    logic               in_use_rs1;
    logic               in_use_rs2;
    logic [XLEN-1:0]    in_imm;
    logic               in_a_sel;
    logic               in_b_sel;
    logic [ALUOP_W-1:0] in_alu_op;
    logic [4:0]         in_rd_addr;
    logic               in_reg_write;
    logic               in_mem_read;
    logic               flush;
    logic [4:0]         exmem_rd_addr;
    logic               exmem_reg_write;
    logic               exmem_mem_read;
    logic [XLEN-1:0]    exmem_result;
    logic [4:0]         memwb_rd_addr;
    logic               memwb_reg_write;
    logic [XLEN-1:0]    memwb_result;
    logic [XLEN-1:0]    alu_a;
    logic [XLEN-1:0]    alu_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               out_valid;
    logic [XLEN-1:0]    out_store_data;
    logic [XLEN-1:0]    out_pc;
    logic [4:0]         out_rd_addr;
    logic               out_reg_write;
    logic               out_mem_read;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_operand_stage #(.XLEN(XLEN), .ALUOP_W(ALUOP_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_imm(in_imm), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
        .in_alu_op(in_alu_op), .in_rd_addr(in_rd_addr),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .flush(flush),
        .exmem_rd_addr(exmem_rd_addr), .exmem_reg_write(exmem_reg_write),
        .exmem_mem_read(exmem_mem_read), .exmem_result(exmem_result),
        .memwb_rd_addr(memwb_rd_addr), .memwb_reg_write(memwb_reg_write),
        .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .out_valid(out_valid),
        .out_store_data(out_store_data), .out_pc(out_pc),
        .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, asel, bsel, rw, mr;
        logic [3:0]  op;
    } instr_t;

    instr_t m;
    bit     m_init = 0;

    // Value a consumer of register r sees: newest producer first, x0 never.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] file_val);
        if (r == 0) return file_val;
        if (exmem_reg_write && exmem_rd_addr == r) return exmem_result;
        if (memwb_reg_write && memwb_rd_addr == r) return memwb_result;
        return file_val;
    endfunction

    // The held instruction must wait while it reads a load still in EX/MEM.
    function automatic logic must_wait();
        if (!m.valid || !exmem_mem_read || !exmem_reg_write || exmem_rd_addr == 0) return 1'b0;
        return (m.u1 && m.rs1 == exmem_rd_addr) || (m.u2 && m.rs2 == exmem_rd_addr);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m = '{valid: 1'b0, pc: 0, d1: 0, d2: 0, imm: 0, rs1: 0, rs2: 0, rd: 0,
                  u1: 0, u2: 0, asel: 0, bsel: 0, rw: 0, mr: 0, op: 0};
            m_init = 1;
        end else if (m_init) begin
            if (flush) begin
                m.valid = 1'b0;
            end else if (!must_wait()) begin
                m = '{valid: in_valid, pc: in_pc, d1: in_rs1_data, d2: in_rs2_data,
                      imm: in_imm, rs1: in_rs1_addr, rs2: in_rs2_addr, rd: in_rd_addr,
                      u1: in_use_rs1, u2: in_use_rs2, asel: in_a_sel, bsel: in_b_sel,
                      rw: in_reg_write, mr: in_mem_read, op: in_alu_op};
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_init && !rst) begin
            logic        live;
            logic [31:0] r1, r2;
            live = m.valid && !must_wait();
            r1 = operand(m.rs1, m.d1);
            r2 = operand(m.rs2, m.d2);
            check("m_in_ready",  {31'b0, in_ready},      {31'b0, (flush || !must_wait())});
            check("m_out_valid", {31'b0, out_valid},     {31'b0, live});
            check("m_reg_write", {31'b0, out_reg_write}, {31'b0, (live && m.rw)});
            check("m_mem_read",  {31'b0, out_mem_read},  {31'b0, (live && m.mr)});
            check("m_alu_a",     alu_a,                  m.asel ? m.pc : r1);
            check("m_alu_b",     alu_b,                  m.bsel ? m.imm : r2);
            check("m_alu_op",    {28'b0, alu_op},        {28'b0, m.op});
            check("m_store",     out_store_data,         r2);
            check("m_pc",        out_pc,                 m.pc);
            check("m_rd",        {27'b0, out_rd_addr},   {27'b0, m.rd});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                             input logic [4:0] rs2, input logic [31:0] d2, input logic u1,
                             input logic u2, input logic [31:0] imm, input logic asel,
                             input logic bsel, input logic [3:0] op, input logic [4:0] rd,
                             input logic rw, input logic mr);
        in_valid = 1; in_pc = pc; in_rs1_addr = rs1; in_rs1_data = d1;
        in_rs2_addr = rs2; in_rs2_data = d2; in_use_rs1 = u1; in_use_rs2 = u2;
        in_imm = imm; in_a_sel = asel; in_b_sel = bsel; in_alu_op = op;
        in_rd_addr = rd; in_reg_write = rw; in_mem_read = mr;
    endtask

    task automatic clear_fwd();
        exmem_rd_addr = 0; exmem_reg_write = 0; exmem_mem_read = 0; exmem_result = 0;
        memwb_rd_addr = 0; memwb_reg_write = 0; memwb_result = 0;
    endtask

    initial begin
        rst = 1; flush = 0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 0;
        clear_fwd();

        // Reset then idle
        repeat (2) edge_step();
        rst = 0;
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        $display("txn reset: out_valid=%0d in_ready=%0d", out_valid, in_ready);
        #1;

        // Plain capture: ADD x3,x1,x2
        set_instr(32'h100, 1, 5, 2, 7, 1, 1, 0, 0, 0, ALU_ADD, 3, 1, 0);
        edge_step();
        in_valid = 0;
        @(negedge clk);
        check("add_alu_a", alu_a, 32'd5);
        check("add_alu_b", alu_b, 32'd7);
        check("add_alu_op", {28'b0, alu_op}, {28'b0, ALU_ADD});
        check("add_out_valid", {31'b0, out_valid}, 32'd1);
        check("add_reg_write", {31'b0, out_reg_write}, 32'd1);
        $display("txn add: a=%h b=%h", alu_a, alu_b);
        #1;

        // Forward priority on rs1=x4
        set_instr(32'h104, 4, 32'h33, 2, 7, 1, 1, 0, 0, 0, ALU_OR, 9, 1, 0);
        edge_step();
        in_valid = 0;
        exmem_rd_addr = 4; exmem_reg_write = 1; exmem_result = 32'h11;
        memwb_rd_addr = 4; memwb_reg_write = 1; memwb_result = 32'h22;
        @(negedge clk);
        check("fwd_exmem", alu_a, 32'h11);
        #1;
        exmem_reg_write = 0;
        #1;
        check("fwd_memwb", alu_a, 32'h22);
        $display("txn fwd: a=%h", alu_a);
        #1;

        // x0 never forwarded
        set_instr(32'h108, 0, 32'h44, 0, 32'h45, 1, 1, 0, 0, 0, ALU_ADD, 9, 1, 0);
        exmem_rd_addr = 0; exmem_reg_write = 1; exmem_result = 32'h11;
        memwb_rd_addr = 0; memwb_reg_write = 1; memwb_result = 32'h22;
        edge_step();
        in_valid = 0;
        @(negedge clk);
        check("fwd_x0_a", alu_a, 32'h44);
        check("fwd_x0_b", alu_b, 32'h45);
        $display("txn x0: a=%h b=%h", alu_a, alu_b);
        #1;
        clear_fwd();

        // Load-use: ADD x6,x5,x1 behind a load to x5
        set_instr(32'h10C, 5, 32'hDEAD, 1, 3, 1, 1, 0, 0, 0, ALU_ADD, 6, 1, 0);
        edge_step();
        exmem_rd_addr = 5; exmem_reg_write = 1; exmem_mem_read = 1; exmem_result = 32'h77;
        set_instr(32'h110, 2, 32'h20, 3, 32'h30, 1, 1, 0, 0, 0, ALU_SUB, 7, 1, 0);
        @(negedge clk);
        check("lu_out_valid", {31'b0, out_valid}, 32'd0);
        check("lu_in_ready", {31'b0, in_ready}, 32'd0);
        check("lu_reg_write", {31'b0, out_reg_write}, 32'd0);
        $display("txn load-use stall: out_valid=%0d in_ready=%0d", out_valid, in_ready);
        #1;
        edge_step();
        clear_fwd();
        memwb_rd_addr = 5; memwb_reg_write = 1; memwb_result = 32'h99;
        @(negedge clk);
        check("lu_fwd_a", alu_a, 32'h99);
        check("lu_fwd_b", alu_b, 32'd3);
        check("lu_resume_valid", {31'b0, out_valid}, 32'd1);
        check("lu_resume_ready", {31'b0, in_ready}, 32'd1);
        $display("txn load-use resume: a=%h", alu_a);
        #1;
        edge_step();
        in_valid = 0;
        clear_fwd();
        @(negedge clk);
        check("held_sub_a", alu_a, 32'h20);
        check("held_sub_b", alu_b, 32'h30);
        check("held_sub_op", {28'b0, alu_op}, {28'b0, ALU_SUB});
        check("held_sub_pc", out_pc, 32'h110);
        $display("txn sub after stall: a=%h b=%h", alu_a, alu_b);
        #1;

        // I-type with rs2 field matching a load but unused: no stall
        set_instr(32'h114, 1, 32'h10, 5, 32'hBB, 1, 0, 32'h8, 0, 1, ALU_ADD, 10, 1, 0);
        edge_step();
        in_valid = 0;
        exmem_rd_addr = 5; exmem_reg_write = 1; exmem_mem_read = 1; exmem_result = 32'h77;
        @(negedge clk);
        check("itype_in_ready", {31'b0, in_ready}, 32'd1);
        check("itype_out_valid", {31'b0, out_valid}, 32'd1);
        check("itype_alu_b", alu_b, 32'h8);
        $display("txn itype: ready=%0d valid=%0d", in_ready, out_valid);
        #1;
        clear_fwd();

        // PC / immediate select with forwarded store data
        set_instr(32'h1000, 1, 32'h10, 8, 32'h55, 1, 1, 32'hFFFF_FFFC, 1, 1, ALU_ADD, 11, 0, 0);
        memwb_rd_addr = 8; memwb_reg_write = 1; memwb_result = 32'h66;
        edge_step();
        in_valid = 0;
        @(negedge clk);
        check("sel_alu_a", alu_a, 32'h1000);
        check("sel_alu_b", alu_b, 32'hFFFF_FFFC);
        check("sel_store", out_store_data, 32'h66);
        check("sel_reg_write", {31'b0, out_reg_write}, 32'd0);
        $display("txn select: a=%h b=%h st=%h", alu_a, alu_b, out_store_data);
        #1;
        clear_fwd();

        // Flush during a load-use stall
        set_instr(32'h200, 5, 32'h1, 0, 0, 1, 0, 0, 0, 1, ALU_ADD, 12, 1, 0);
        edge_step();
        exmem_rd_addr = 5; exmem_reg_write = 1; exmem_mem_read = 1;
        flush = 1;
        set_instr(32'h204, 1, 32'hAA, 2, 32'hAB, 1, 1, 0, 0, 0, ALU_ADD, 13, 1, 0);
        @(negedge clk);
        check("fl_out_valid", {31'b0, out_valid}, 32'd0);
        check("fl_in_ready", {31'b0, in_ready}, 32'd1);
        #1;
        edge_step();
        flush = 0;
        clear_fwd();
        set_instr(32'h208, 2, 32'hCC, 3, 32'hDD, 1, 1, 0, 0, 0, ALU_OR, 14, 1, 0);
        @(negedge clk);
        check("fl_killed_valid", {31'b0, out_valid}, 32'd0);
        check("fl_killed_ready", {31'b0, in_ready}, 32'd1);
        check("fl_discard_pc", out_pc, 32'h200);
        #1;
        edge_step();
        in_valid = 0;
        @(negedge clk);
        check("fl_next_valid", {31'b0, out_valid}, 32'd1);
        check("fl_next_a", alu_a, 32'hCC);
        check("fl_next_pc", out_pc, 32'h208);
        $display("txn flush: next pc=%h", out_pc);
        #1;

        // Reset in the middle of a stall
        set_instr(32'h300, 5, 32'h1, 0, 0, 1, 0, 0, 0, 0, ALU_ADD, 15, 1, 1);
        edge_step();
        in_valid = 0;
        exmem_rd_addr = 5; exmem_reg_write = 1; exmem_mem_read = 1;
        @(negedge clk);
        check("rs_stall_ready", {31'b0, in_ready}, 32'd0);
        #1;
        rst = 1;
        edge_step();
        rst = 0;
        @(negedge clk);
        check("rs_out_valid", {31'b0, out_valid}, 32'd0);
        check("rs_in_ready", {31'b0, in_ready}, 32'd1);
        check("rs_pc", out_pc, 32'd0);
        check("rs_mem_read", {31'b0, out_mem_read}, 32'd0);
        $display("txn reset mid-stall: ready=%0d", in_ready);
        #1;
        clear_fwd();

        repeat (3) edge_step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
